// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: FSM state type and register-address constants.
package pipe_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_sat_counter.sv
// Parameterised saturating up-counter with enable and asynchronous active-low clear.
module hazard_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = 1;

    // Count enabled cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, jump squashing and
// mult/div freeze, with a saturating stall-cycle counter.
// Optional mult/div wait timeout enabled by defining HAZARD_MD_TIMEOUT_EN.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = 40,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs_d,
    input  logic [REG_ADDR_W-1:0] rt_d,
    input  logic                  uses_rt_d,
    input  logic                  jump1_d,
    input  logic [REG_ADDR_W-1:0] rd_x,
    input  logic                  wen_x,
    input  logic                  load_x,
    input  logic                  jump2_x,
    input  logic                  md_start_x,
    input  logic                  md_rdy,
    output logic                  stall_fd,
    output logic                  bubble_dx,
    output logic                  flush_fd,
    output logic                  md_busy,
    output logic                  md_timeout,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int unsigned WAIT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_ONE = 1;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              wait_expired;

`ifdef HAZARD_MD_TIMEOUT_EN
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);
    logic md_timeout_r;

    assign wait_expired = (wait_cnt == WAIT_LAST);
    assign md_timeout   = md_timeout_r;
`else
    assign wait_expired = 1'b0;
    assign md_timeout   = 1'b0;
`endif

    assign md_busy = (state == MD_WAIT);

    // Load-use match of the execute-stage load against decode read ports; r0 never hazards.
    always_comb begin
        load_use = load_x && wen_x && (rd_x != REG_ZERO) &&
                   ((rd_x == rs_d) || (uses_rt_d && (rd_x == rt_d)));
    end

    // Mealy control outputs, forced low while reset is asserted.
    always_comb begin
        stall_fd  = 1'b0;
        bubble_dx = 1'b0;
        flush_fd  = 1'b0;
        if (rst) begin
            case (state)
                RUN: begin
                    if (jump2_x) begin
                        flush_fd  = 1'b1;
                        bubble_dx = 1'b1;
                    end else if (md_start_x) begin
                        // Issuing instruction advances; freeze starts next cycle.
                    end else if (load_use) begin
                        stall_fd  = 1'b1;
                        bubble_dx = 1'b1;
                    end else if (jump1_d) begin
                        flush_fd  = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (!md_rdy && !wait_expired) begin
                        stall_fd  = 1'b1;
                        bubble_dx = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and mult/div wait counter; jump2_x and md_start_x are ignored while waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
`ifdef HAZARD_MD_TIMEOUT_EN
            md_timeout_r <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (!jump2_x && md_start_x) begin
                        state    <= MD_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MD_WAIT: begin
                    if (md_rdy) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_expired) begin
                        state    <= RUN;
                        wait_cnt <= '0;
`ifdef HAZARD_MD_TIMEOUT_EN
                        md_timeout_r <= 1'b1;
`endif
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_ONE;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    hazard_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr_n (rst),
        .en    (stall_fd),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a rule-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_hazard_ctrl;

    localparam int unsigned MD_TIMEOUT = 40;
`ifdef HAZARD_MD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] rs_d = '0, rt_d = '0, rd_x = '0;
    logic       uses_rt_d = 0, jump1_d = 0, wen_x = 0, load_x = 0;
    logic       jump2_x = 0, md_start_x = 0, md_rdy = 0;

    logic        stall_fd, bubble_dx, flush_fd, md_busy, md_timeout;
    logic [15:0] stall_cnt;
    logic        s_stall_fd, s_bubble_dx, s_flush_fd, s_md_busy, s_md_timeout;
    logic [3:0]  s_stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .uses_rt_d(uses_rt_d),
        .jump1_d(jump1_d), .rd_x(rd_x), .wen_x(wen_x), .load_x(load_x),
        .jump2_x(jump2_x), .md_start_x(md_start_x), .md_rdy(md_rdy),
        .stall_fd(stall_fd), .bubble_dx(bubble_dx), .flush_fd(flush_fd),
        .md_busy(md_busy), .md_timeout(md_timeout), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .uses_rt_d(uses_rt_d),
        .jump1_d(jump1_d), .rd_x(rd_x), .wen_x(wen_x), .load_x(load_x),
        .jump2_x(jump2_x), .md_start_x(md_start_x), .md_rdy(md_rdy),
        .stall_fd(s_stall_fd), .bubble_dx(s_bubble_dx), .flush_fd(s_flush_fd),
        .md_busy(s_md_busy), .md_timeout(s_md_timeout), .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_waiting;
    int m_wait_cycles;
    bit m_timeout;
    int m_cnt_big;
    int m_cnt_small;

    function automatic bit hazard();
        return load_x && wen_x && rd_x != 0 &&
               (rd_x == rs_d || (uses_rt_d && rd_x == rt_d));
    endfunction

    // Expected {stall, bubble, flush} from the control rules.
    function automatic logic [2:0] expect_out();
        if (!rst) return 3'b000;
        if (m_waiting) begin
            if (md_rdy) return 3'b000;
            if (TO_EN && m_wait_cycles == MD_TIMEOUT - 1) return 3'b000;
            return 3'b110;
        end
        if (jump2_x)    return 3'b011;
        if (md_start_x) return 3'b000;
        if (hazard())   return 3'b110;
        if (jump1_d)    return 3'b001;
        return 3'b000;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_waiting = 0; m_wait_cycles = 0; m_timeout = 0;
            m_cnt_big = 0; m_cnt_small = 0;
        end else begin
            logic [2:0] e;
            e = expect_out();
            if (e[2]) begin
                if (m_cnt_big < 65535) m_cnt_big++;
                if (m_cnt_small < 15)  m_cnt_small++;
            end
            if (m_waiting) begin
                if (md_rdy) begin
                    m_waiting = 0;
                end else if (TO_EN && m_wait_cycles == MD_TIMEOUT - 1) begin
                    m_waiting = 0; m_timeout = 1;
                end else begin
                    m_wait_cycles++;
                end
            end else if (!jump2_x && md_start_x) begin
                m_waiting = 1; m_wait_cycles = 0;
            end
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [2:0] e;
        e = expect_out();
        chk("model_stall",   stall_fd,    e[2]);
        chk("model_bubble",  bubble_dx,   e[1]);
        chk("model_flush",   flush_fd,    e[0]);
        chk("model_busy",    md_busy,     rst && m_waiting);
        chk("model_timeout", md_timeout,  m_timeout);
        chk("model_cnt",     stall_cnt,   m_cnt_big);
        chk("model_cnt_sat", s_stall_cnt, m_cnt_small);
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs_d = 0; rt_d = 0; rd_x = 0; uses_rt_d = 0; jump1_d = 0;
        wen_x = 0; load_x = 0; jump2_x = 0; md_start_x = 0; md_rdy = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        step();
        rst = 1;
    endtask

    initial begin
        idle();
        step(); step();
        #3;
        chk("reset_cnt",  stall_cnt, 0);
        chk("reset_busy", md_busy,   0);
        chk("reset_stall", stall_fd, 0);
        step();
        rst = 1;

        // Load-use on rs
        load_x = 1; wen_x = 1; rd_x = 5; rs_d = 5;
        #3;
        chk("lu_rs_stall",  stall_fd,  1);
        chk("lu_rs_bubble", bubble_dx, 1);
        step();
        idle();
        #3;
        chk("lu_rs_cnt", stall_cnt, 1);
        chk("lu_rs_released", stall_fd, 0);

        // r0 never hazards
        step();
        load_x = 1; wen_x = 1; rd_x = 0; rs_d = 0;
        #3;
        chk("lu_r0_stall", stall_fd, 0);

        // rt match depends on uses_rt_d
        step();
        rd_x = 7; rs_d = 3; rt_d = 7; uses_rt_d = 1;
        step();
        uses_rt_d = 0;
        #3;
        chk("lu_rt_unused", stall_fd, 0);
        step();
        idle();

        // jump2 dominates load-use and jump1, then jump1 alone
        load_x = 1; wen_x = 1; rd_x = 9; rs_d = 9; jump2_x = 1; jump1_d = 1;
        #3;
        chk("j2_flush",  flush_fd,  1);
        chk("j2_bubble", bubble_dx, 1);
        chk("j2_stall",  stall_fd,  0);
        step();
        idle();
        jump1_d = 1;
        #3;
        chk("j1_flush",  flush_fd,  1);
        chk("j1_bubble", bubble_dx, 0);
        step();
        idle();
        md_rdy = 1;   // ignored in RUN
        step();

        // mult/div with md_rdy 17 cycles after issue
        do_reset();
        md_start_x = 1;
        step();
        md_start_x = 0;
        for (int k = 1; k <= 16; k++) begin
            jump2_x    = (k == 3);
            md_start_x = (k == 4);
            #3;
            chk("md_busy_wait",  md_busy,  1);
            chk("md_stall_wait", stall_fd, 1);
            step();
        end
        idle();
        md_rdy = 1;
        #3;
        chk("md_rdy_stall", stall_fd,  0);
        chk("md_rdy_bub",   bubble_dx, 0);
        step();
        idle();
        #3;
        chk("md_back_run", md_busy,   0);
        chk("md_cnt16",    stall_cnt, 16);

        // wait without md_rdy
        do_reset();
        md_start_x = 1;
        step();
        md_start_x = 0;
`ifdef HAZARD_MD_TIMEOUT_EN
        for (int k = 1; k <= 40; k++) begin
            #3;
            chk("to_stall", stall_fd, (k < 40) ? 1 : 0);
            step();
        end
        #3;
        chk("to_busy", md_busy,    0);
        chk("to_flag", md_timeout, 1);
        step(); step();
        chk("to_sticky", md_timeout, 1);
`else
        for (int k = 1; k < 100; k++) step();
        #3;
        chk("persist_stall100", stall_fd,   1);
        chk("persist_timeout",  md_timeout, 0);
        step();
        md_rdy = 1;
        step();
        idle();
`endif

        // asynchronous reset in the middle of a wait
        do_reset();
        md_start_x = 1;
        step();
        md_start_x = 0;
        for (int k = 1; k <= 5; k++) step();
        #1;
        rst = 0;
        #1;
        chk("arst_stall", stall_fd,  0);
        chk("arst_bub",   bubble_dx, 0);
        chk("arst_busy",  md_busy,   0);
        chk("arst_cnt",   stall_cnt, 0);
        step();
        rst = 1;
        step();
        #3;
        chk("arst_after_busy",  md_busy,  0);
        chk("arst_after_stall", stall_fd, 0);

        // saturation of the 4-bit counter
        do_reset();
        load_x = 1; wen_x = 1; rd_x = 12; rs_d = 12;
        for (int k = 0; k < 19; k++) step();
        idle();
        #3;
        chk("sat_small", s_stall_cnt, 15);
        chk("sat_big",   stall_cnt,   19);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
